// File: rtl/clk_rst_sequencer_pkg.sv
// rtl/clk_rst_sequencer_pkg.sv - shared state encodings and default parameters for clk_rst_sequencer
//
// Purpose: sequencer state encoding plus the default timing parameters used
// by clk_rst_sequencer and anything that needs to decode its state.
// Ports: none (package).

package clk_rst_sequencer_pkg;

   typedef enum logic [2:0] {
      SEQ_PLL_RST   = 3'd0,
      SEQ_WAIT_LOCK = 3'd1,
      SEQ_STABILIZE = 3'd2,
      SEQ_RUN       = 3'd3,
      SEQ_FAULT     = 3'd4
   } seq_state_t;

   localparam int unsigned DEF_PLL_RST_CYCLES = 16;
   localparam int unsigned DEF_LOCK_TIMEOUT   = 65536;
   localparam int unsigned DEF_STABLE_CYCLES  = 256;
   localparam int unsigned DEF_MAX_RETRY      = 4;
   localparam int unsigned DEF_CNT_W          = 17;

endpackage

// File: rtl/clk_rst_sequencer_sync_2ff.sv
// rtl/clk_rst_sequencer_sync_2ff.sv - parameterizable-width two-flop synchronizer
//
// Purpose: brings W asynchronous bits into the clk domain through two flops.
// Both flop stages clear to 0 on reset.
// Ports:
//   clk  in   destination-domain clock
//   rst  in   asynchronous active-high reset
//   d    in   W asynchronous input bits
//   q    out  W synchronized bits

module sync_2ff #(
   parameter int unsigned W = 1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);

   logic [W-1:0] meta;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         meta <= '0;
         q    <= '0;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/clk_rst_sequencer.sv
// rtl/clk_rst_sequencer.sv - clock-manager supervisor and core reset sequencer
//
// Purpose: pulses the clock manager reset, waits for lock with timeout and
// retry limit, holds core reset until lock has been stable, and re-sequences
// on lock loss or a soft-reset request. Runs on the free-running clock.
// Optional macro CLK_RST_SEQ_STATS_EN adds a saturating lock-loss counter.
// Ports:
//   clk           in   free-running oscillator-domain clock
//   reset         in   asynchronous active-high reset
//   locked        in   clock-manager lock, asynchronous to clk
//   soft_rst_req  in   synchronous pulse: core reset without PLL reset
//   pll_reset     out  clock-manager reset, active-high, registered
//   sys_reset     out  core reset, active-high, registered
//   ready         out  high only in RUN, registered
//   fault         out  sticky lock failure, registered
//   loss_count    out  [7:0] lock-loss events (CLK_RST_SEQ_STATS_EN only)

module clk_rst_sequencer
   import clk_rst_sequencer_pkg::*;
#(
   parameter int unsigned PLL_RST_CYCLES = DEF_PLL_RST_CYCLES,
   parameter int unsigned LOCK_TIMEOUT   = DEF_LOCK_TIMEOUT,
   parameter int unsigned STABLE_CYCLES  = DEF_STABLE_CYCLES,
   parameter int unsigned MAX_RETRY      = DEF_MAX_RETRY,
   parameter int unsigned CNT_W          = DEF_CNT_W
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       locked,
   input  logic       soft_rst_req,
   output logic       pll_reset,
   output logic       sys_reset,
   output logic       ready,
   output logic       fault
`ifdef CLK_RST_SEQ_STATS_EN
   ,
   output logic [7:0] loss_count
`endif
);

   localparam int unsigned RETRY_W = $clog2(MAX_RETRY + 1);

   localparam logic [CNT_W-1:0]   PLL_LAST    = CNT_W'(PLL_RST_CYCLES - 1);
   localparam logic [CNT_W-1:0]   TO_LAST     = CNT_W'(LOCK_TIMEOUT - 1);
   localparam logic [CNT_W-1:0]   STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);
   localparam logic [RETRY_W-1:0] RETRY_MAX   = RETRY_W'(MAX_RETRY);

   seq_state_t         state, state_n;
   logic [CNT_W-1:0]   cnt, cnt_n;
   logic [RETRY_W-1:0] retry, retry_n;
   logic               locked_s;

   sync_2ff #(.W(1)) u_lock_sync (
      .clk (clk),
      .rst (reset),
      .d   (locked),
      .q   (locked_s)
   );

   always_comb begin
      state_n = state;
      cnt_n   = cnt + 1'b1;
      retry_n = retry;
      case (state)
         SEQ_PLL_RST: begin
            if (cnt == PLL_LAST) begin
               state_n = SEQ_WAIT_LOCK;
               cnt_n   = '0;
            end
         end
         SEQ_WAIT_LOCK: begin
            // Lock is checked first so a lock arriving on the timeout cycle is kept.
            if (locked_s) begin
               state_n = SEQ_STABILIZE;
               cnt_n   = '0;
            end else if (cnt == TO_LAST) begin
               retry_n = retry + 1'b1;
               cnt_n   = '0;
               state_n = (retry_n == RETRY_MAX) ? SEQ_FAULT : SEQ_PLL_RST;
            end
         end
         SEQ_STABILIZE: begin
            // Retry count is kept on lock loss here: lock was achieved, so
            // this is not a timeout. A soft request on the final count
            // restarts the interval rather than releasing reset.
            if (!locked_s) begin
               state_n = SEQ_PLL_RST;
               cnt_n   = '0;
            end else if (soft_rst_req) begin
               cnt_n = '0;
            end else if (cnt == STABLE_LAST) begin
               state_n = SEQ_RUN;
               cnt_n   = '0;
               retry_n = '0;
            end
         end
         SEQ_RUN: begin
            cnt_n = '0;
            if (!locked_s) begin
               state_n = SEQ_PLL_RST;
            end else if (soft_rst_req) begin
               state_n = SEQ_STABILIZE;
            end
         end
         SEQ_FAULT: begin
            cnt_n = cnt;
         end
         default: begin
            state_n = SEQ_PLL_RST;
            cnt_n   = '0;
            retry_n = '0;
         end
      endcase
   end

   // Outputs are decoded from the next state so they change on the same
   // edge as the state they describe.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= SEQ_PLL_RST;
         cnt       <= '0;
         retry     <= '0;
         pll_reset <= 1'b1;
         sys_reset <= 1'b1;
         ready     <= 1'b0;
         fault     <= 1'b0;
      end else begin
         state     <= state_n;
         cnt       <= cnt_n;
         retry     <= retry_n;
         pll_reset <= (state_n == SEQ_PLL_RST);
         sys_reset <= (state_n != SEQ_RUN);
         ready     <= (state_n == SEQ_RUN);
         fault     <= (state_n == SEQ_FAULT);
      end
   end

`ifdef CLK_RST_SEQ_STATS_EN
   logic lock_lost;

   assign lock_lost = ((state == SEQ_RUN) || (state == SEQ_STABILIZE)) && !locked_s;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         loss_count <= '0;
      end else if (lock_lost && (loss_count != 8'hFF)) begin
         loss_count <= loss_count + 8'd1;
      end
   end
`endif

endmodule

// File: tb/tb_clk_rst_sequencer.sv
// tb/tb_clk_rst_sequencer.sv - directed self-checking bench for clk_rst_sequencer

module tb_clk_rst_sequencer;

   localparam int unsigned PLL_RST_CYCLES = 4;
   localparam int unsigned LOCK_TIMEOUT   = 32;
   localparam int unsigned STABLE_CYCLES  = 8;
   localparam int unsigned MAX_RETRY      = 2;
   localparam int unsigned CNT_W          = 6;

   logic clk = 1'b0;
   logic reset;
   logic locked;
   logic soft_rst_req;
   logic pll_reset;
   logic sys_reset;
   logic ready;
   logic fault;
`ifdef CLK_RST_SEQ_STATS_EN
   logic [7:0] loss_count;
`endif

   int cyc;
   int checks;
   int errors;
   int t;

   always #5 clk = ~clk;

   clk_rst_sequencer #(
      .PLL_RST_CYCLES (PLL_RST_CYCLES),
      .LOCK_TIMEOUT   (LOCK_TIMEOUT),
      .STABLE_CYCLES  (STABLE_CYCLES),
      .MAX_RETRY      (MAX_RETRY),
      .CNT_W          (CNT_W)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .locked       (locked),
      .soft_rst_req (soft_rst_req),
      .pll_reset    (pll_reset),
      .sys_reset    (sys_reset),
      .ready        (ready),
      .fault        (fault)
`ifdef CLK_RST_SEQ_STATS_EN
      ,
      .loss_count   (loss_count)
`endif
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Cycle n is the period ending at rising edge n; sampling is at the falling edge.
   task automatic step();
      @(posedge clk);
      @(negedge clk);
      cyc++;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      cyc   = 0;
   endtask

   task automatic wait_ready(input string tag);
      int n;
      n = 0;
      while (!ready && n < 200) begin
         step();
         n++;
      end
      check(tag, ready, 1);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      checks       = 0;
      errors       = 0;
      cyc          = 0;
      reset        = 1'b1;
      locked       = 1'b0;
      soft_rst_req = 1'b0;

      repeat (2) @(negedge clk);
      check("rst_pll_reset", pll_reset, 1);
      check("rst_sys_reset", sys_reset, 1);
      check("rst_ready",     ready,     0);
      check("rst_fault",     fault,     0);

      // Power-up with lock rising in cycle 10.
      do_reset();
      for (int c = 0; c <= 24; c++) begin
         if (c == 10) locked = 1'b1;
         check($sformatf("pwr_pll c%0d", c),   pll_reset, (c <= 3));
         check($sformatf("pwr_sys c%0d", c),   sys_reset, (c < 21));
         check($sformatf("pwr_ready c%0d", c), ready,     (c >= 21));
         step();
      end

      // Soft reset pulse in RUN: sys_reset high for exactly 8 cycles.
      soft_rst_req = 1'b1;
      step();
      soft_rst_req = 1'b0;
      for (int k = 1; k <= 9; k++) begin
         check($sformatf("soft_sys k%0d", k),   sys_reset, (k <= 8));
         check($sformatf("soft_pll k%0d", k),   pll_reset, 0);
         check($sformatf("soft_ready k%0d", k), ready,     (k == 9));
         step();
      end

      // Lock dropped for 3 cycles in RUN, then full re-sequence.
      locked = 1'b0;
      step();
      step();
      check("drop_pre_ready", ready,     1);
      check("drop_pre_pll",   pll_reset, 0);
      step();
      locked = 1'b1;
      check("drop_sys", sys_reset, 1);
`ifdef CLK_RST_SEQ_STATS_EN
      check("drop_loss_count", loss_count, 1);
`endif
      for (int k = 3; k <= 16; k++) begin
         check($sformatf("drop_pll k%0d", k),   pll_reset, (k <= 6));
         check($sformatf("drop_ready k%0d", k), ready,     (k >= 16));
         check($sformatf("drop_sys k%0d", k),   sys_reset, (k < 16));
         step();
      end

      // Soft request coincides with synchronized lock loss: lock loss wins.
      locked = 1'b0;
      step();
      step();
      soft_rst_req = 1'b1;
      check("sim_pre_ready", ready, 1);
      step();
      soft_rst_req = 1'b0;
      check("sim_pll", pll_reset, 1);
      check("sim_sys", sys_reset, 1);
      check("sim_ready", ready, 0);
      locked = 1'b1;
      wait_ready("sim_rerun_ready");
`ifdef CLK_RST_SEQ_STATS_EN
      check("sim_loss_count", loss_count, 2);
`endif

      // One timeout (retry=1), lock in STABILIZE, reset at count 5.
      locked = 1'b0;
      do_reset();
      for (int c = 0; c <= 47; c++) begin
         if (c == 40) locked = 1'b1;
         check($sformatf("retry_pll c%0d", c),   pll_reset, (c <= 3) || (c >= 36 && c <= 39));
         check($sformatf("retry_fault c%0d", c), fault,     0);
         check($sformatf("retry_sys c%0d", c),   sys_reset, 1);
         step();
      end
      check("stab_pll_before_rst", pll_reset, 0);
      #2;
      reset = 1'b1;
      #1;
      check("async_pll", pll_reset, 1);
      check("async_sys", sys_reset, 1);
      check("async_ready", ready, 0);
      check("async_fault", fault, 0);
`ifdef CLK_RST_SEQ_STATS_EN
      check("async_loss_count", loss_count, 0);
`endif

      // Restart with lock held low: retry must start from 0, fault at cycle 72.
      locked = 1'b0;
      do_reset();
      for (int c = 0; c <= 100; c++) begin
         if (c == 75) locked = 1'b1;
         check($sformatf("flt_pll c%0d", c),   pll_reset, (c <= 3) || (c >= 36 && c <= 39));
         check($sformatf("flt_fault c%0d", c), fault,     (c >= 72));
         check($sformatf("flt_sys c%0d", c),   sys_reset, 1);
         check($sformatf("flt_ready c%0d", c), ready,     0);
         step();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
